mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store front end sitting directly upstream of the word-wide data RAM.
//  Accepts MIPS byte-addressed lw/lh/lhu/lb/lbu/sw/sh/sb requests from the MEM stage.
//  Drives the RAM word port (addr/D_in/str/ld) and does read-modify-write for sh/sb.
//  Returns sign/zero-extended load data and flags misaligned or out-of-range accesses.
// PARAMETERS
//  ADDR_W   10   RAM word-address width; byte space = 2**(ADDR_W+2) bytes
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active high
//  req_valid   in   1       request present
//  req_ready   out  1       unit idle, can accept request
//  req_we      in   1       1=store, 0=load
//  req_size    in   2       00=byte, 01=half, 10=word, 11=illegal
//  req_unsigned in  1       loads only: 1=zero-extend, 0=sign-extend
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid  out  1       one-cycle completion pulse
//  resp_err    out  1       valid with resp_valid: misaligned/out-of-range, no RAM access
//  resp_rdata  out  32      load result, valid with resp_valid (0 for stores/errors)
//  ram_addr    out  ADDR_W  RAM word address
//  ram_din     out  32      RAM write data
//  ram_str     out  1       RAM write strobe (written on clk rising edge)
//  ram_ld      out  1       RAM read enable
//  ram_dout    in   32      RAM read data, combinational from ram_addr, 0 when ram_ld=0
// BEHAVIOUR
//  - Reset (async): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
//    Also ram_addr=0, ram_din=0, ram_str=0, ram_ld=0.
//  - FSM states: IDLE, RD, WR, RESP. req_ready=1 only in IDLE.
//  - Accept on req_valid&&req_ready; all req_* latched then, ignored afterwards.
//  - Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]!=0.
//    Also error if addr[31:ADDR_W+2]!=0. Error -> RESP next cycle with resp_err=1.
//    An errored request never asserts ram_str or ram_ld.
//  - Transitions, T = accept cycle:
//    load:       IDLE->RD(T+1)->RESP(T+2)
//    sw:         IDLE->WR(T+1)->RESP(T+2)
//    sh/sb:      IDLE->RD(T+1)->WR(T+2)->RESP(T+3)
//    error:      IDLE->RESP(T+1)
//    RESP->IDLE always; resp_valid=1 only in RESP.
//  - RD: ram_ld=1, ram_addr=addr[ADDR_W+1:2]; ram_dout captured into word reg at clk edge.
//  - WR: ram_str=1, ram_addr latched.
//    sw: ram_din = wdata.
//    sh/sb: ram_din = captured word with the target lane replaced by wdata[15:0]/[7:0].
//  - ram_str/ram_ld are 0 in IDLE and RESP. ram_addr holds its last value in IDLE/RESP.
//  - Byte lanes are big-endian:
//    offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
//    half offset 0 = [31:16], half offset 2 = [15:0].
//  - Loads: extract lane from captured word, then extend per req_unsigned.
//    Word loads ignore req_unsigned.
//  - Reset during WR: ram_str drops asynchronously before the edge, so no partial write.
//    A request in flight is dropped with no response.
//  - Throughput: one request per 3 cycles (lw/sw), 4 (sh/sb), 2 (error).
// TESTING
//  1. sw 0x12345678 @0x10, then lw @0x10:
//     ram_str pulses at T+1; lw resp_valid at T+2 with rdata=0x12345678, err=0.
//  2. sb 0xAB @0x11 over 0x12345678:
//     RAM word 4 becomes 0x12AB5678; resp at T+3.
//     lb @0x11 -> 0xFFFFFFAB; lbu @0x11 -> 0x000000AB.
//  3. sh 0x8001 @0x12 -> word 0x12AB8001.
//     lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001.
//  4. lw @0x13, sh @0x11, size=11, and lw @0x1000:
//     each gives resp_err=1 at T+1, rdata=0; ram_str and ram_ld never high.
//  5. Assert rst mid-WR of sb @0x11:
//     ram_str falls the same cycle; word 4 unchanged; no resp_valid.
//     After release req_ready=1.
//  6. req_valid held high with 3 back-to-back lw:
//     req_ready low while busy; accepts at T, T+3, T+6; exactly three resp_valid pulses.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS byte-addressed load/store front end for a word-wide data RAM
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready      request handshake; ready only while idle
//   req_we, req_size         1=store/0=load; 00=byte, 01=half, 10=word, 11=illegal
//   req_unsigned             loads: 1=zero-extend, 0=sign-extend
//   req_addr, req_wdata      byte address; right-justified store data
//   resp_valid/err/rdata     one-cycle completion pulse, error flag, extended load data
//   ram_addr/din/str/ld      RAM word port; ram_dout is combinational read data
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_str,
    output logic              ram_ld,
    input  logic [31:0]       ram_dout
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t state, state_n;
    logic we_q, uns_q, err_q, acc, err_in;
    logic [1:0] size_q, off_q;
    logic [31:0] wdata_q, word_q, lane_bits, lane_mask, merged, load_v;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0] lane_sh;
    logic [15:0] lane_val;
    assign acc = req_valid && req_ready;
    assign err_in = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_W+2]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q <= 1'b0;
            uns_q <= 1'b0;
            err_q <= 1'b0;
            size_q <= 2'b00;
            off_q <= 2'b00;
            wdata_q <= '0;
            word_q <= '0;
            addr_q <= '0;
        end else begin
            if (acc) begin
                we_q <= req_we;
                uns_q <= req_unsigned;
                err_q <= err_in;
                size_q <= req_size;
                off_q <= req_addr[1:0];
                wdata_q <= req_wdata;
                // errored requests leave the RAM address untouched
                if (!err_in) addr_q <= req_addr[ADDR_W+1:2];
            end
            if (state == RD) word_q <= ram_dout;
        end
    end
    always_comb begin
        state_n = state == IDLE ? (acc ? (err_in ? RESP : (req_we && req_size == 2'b10) ? WR : RD) : IDLE)
                : state == RD   ? (we_q ? WR : RESP)
                : state == WR   ? RESP
                : IDLE;
    end
    always_comb begin
        // big-endian lanes: byte offset 0 is [31:24], half offset 0 is [31:16]
        lane_sh = size_q == 2'b00 ? {~off_q, 3'b000} : {~off_q[1], 4'b0000};
        lane_bits = size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF;
        lane_mask = lane_bits << lane_sh;
        merged = (word_q & ~lane_mask) | ((wdata_q & lane_bits) << lane_sh);
        lane_val = 16'((word_q & lane_mask) >> lane_sh);
        load_v = size_q == 2'b10 ? word_q
               : size_q == 2'b01 ? {{16{~uns_q & lane_val[15]}}, lane_val}
               : {{24{~uns_q & lane_val[7]}}, lane_val[7:0]};
        req_ready = state == IDLE;
        resp_valid = state == RESP;
        resp_err = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !we_q) ? load_v : '0;
        ram_ld = state == RD;
        ram_str = state == WR;
        ram_addr = addr_q;
        ram_din = ram_str ? (size_q == 2'b10 ? wdata_q : merged) : '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a behavioural RAM
module tb_mem_access_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic resp_valid, resp_err;
    logic [31:0] resp_rdata, ram_din, ram_dout;
    logic [9:0] ram_addr;
    logic ram_str, ram_ld;
    logic [31:0] mem [1024];
    int errors = 0, checks = 0;
    int lat, str_at, str_cnt, ld_cnt, resp_cnt;
    logic [31:0] rd;
    logic er;

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_str(ram_str), .ram_ld(ram_ld), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;
    assign ram_dout = ram_ld ? mem[ram_addr] : 32'h0;
    always @(posedge clk) if (ram_str) mem[ram_addr] <= ram_din;

    // Issue one request at a negedge and observe the following 8 cycles.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_req: got %b want 1", req_ready);
        end
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hDEAD_BEEF;
        req_addr = 32'hFFFF_FFFF;
        lat = 0; str_at = 0; str_cnt = 0; ld_cnt = 0; resp_cnt = 0; rd = 'x; er = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            if (ram_str) begin str_cnt++; str_at = k; end
            if (ram_ld) ld_cnt++;
            if (resp_valid) begin
                resp_cnt++;
                if (lat == 0) begin lat = k; rd = resp_rdata; er = resp_err; end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_resp(input string name, input int exp_lat, input logic [31:0] exp_rd,
                              input logic exp_er, input int exp_str, input int exp_ld);
        checks++;
        if (lat !== exp_lat || resp_cnt !== 1) begin
            errors++;
            $display("FAIL %s latency: got %0d (pulses %0d) want %0d (pulses 1)", name, lat, resp_cnt, exp_lat);
        end
        checks++;
        if (rd !== exp_rd || er !== exp_er) begin
            errors++;
            $display("FAIL %s resp: got rdata=%h err=%b want rdata=%h err=%b", name, rd, er, exp_rd, exp_er);
        end
        checks++;
        if (str_cnt !== exp_str || ld_cnt !== exp_ld) begin
            errors++;
            $display("FAIL %s ram strobes: got str=%0d ld=%0d want str=%0d ld=%0d", name, str_cnt, ld_cnt, exp_str, exp_ld);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, ram_str, ram_ld} !== 5'b10000 ||
            resp_rdata !== 32'h0 || ram_addr !== 10'h0 || ram_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b rv=%b re=%b str=%b ld=%b rd=%h ad=%h din=%h want 1 0 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_err, ram_str, ram_ld, resp_rdata, ram_addr, ram_din);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
        check_resp("sw", 2, 32'h0, 1'b0, 1, 0);
        checks++;
        if (str_at !== 1 || mem[4] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL sw_write: got str_at=%0d mem4=%h want 1 12345678", str_at, mem[4]);
        end
        run_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        check_resp("lw", 2, 32'h1234_5678, 1'b0, 0, 1);
    endtask

    task automatic test_byte();
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB);
        check_resp("sb", 3, 32'h0, 1'b0, 1, 1);
        checks++;
        if (str_at !== 2 || mem[4] !== 32'h12AB_5678) begin
            errors++;
            $display("FAIL sb_write: got str_at=%0d mem4=%h want 2 12ab5678", str_at, mem[4]);
        end
        run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        check_resp("lb", 2, 32'hFFFF_FFAB, 1'b0, 0, 1);
        run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        check_resp("lbu", 2, 32'h0000_00AB, 1'b0, 0, 1);
        run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        check_resp("lb_pos", 2, 32'h0000_0012, 1'b0, 0, 1);
    endtask

    task automatic test_half();
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h5555_8001);
        check_resp("sh", 3, 32'h0, 1'b0, 1, 1);
        checks++;
        if (mem[4] !== 32'h12AB_8001) begin
            errors++;
            $display("FAIL sh_write: got mem4=%h want 12ab8001", mem[4]);
        end
        run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check_resp("lh", 2, 32'hFFFF_8001, 1'b0, 0, 1);
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        check_resp("lhu", 2, 32'h0000_8001, 1'b0, 0, 1);
        run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        check_resp("lh_hi", 2, 32'h0000_12AB, 1'b0, 0, 1);
    endtask

    task automatic test_errors();
        run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        check_resp("err_lw_misaligned", 1, 32'h0, 1'b1, 0, 0);
        run_req(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF);
        check_resp("err_sh_misaligned", 1, 32'h0, 1'b1, 0, 0);
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        check_resp("err_size11", 1, 32'h0, 1'b1, 0, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        check_resp("err_range", 1, 32'h0, 1'b1, 0, 0);
        checks++;
        if (mem[4] !== 32'h12AB_8001) begin
            errors++;
            $display("FAIL err_no_write: got mem4=%h want 12ab8001", mem[4]);
        end
    endtask

    task automatic test_reset_mid_write();
        int pulses = 0;
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h11; req_wdata = 32'hCD;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_str !== 1'b1) begin
            errors++;
            $display("FAIL rst_wr_reached: got str=%b want 1", ram_str);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ram_str !== 1'b0) begin
            errors++;
            $display("FAIL rst_str_drop: got str=%b want 0", ram_str);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (resp_valid) pulses++;
            @(negedge clk);
        end
        checks++;
        if (mem[4] !== 32'h12AB_8001 || pulses !== 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wr: got mem4=%h resp=%0d rdy=%b want 12ab8001 0 1", mem[4], pulses, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0, nresp = 0, busy_bad = 0;
        int acc_k [3];
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (req_valid && req_ready) begin
                if (acc < 3) acc_k[acc] = k;
                acc++;
            end
            if (req_ready !== ((k % 3) == 0 || k > 8)) busy_bad++;
            if (resp_valid) begin
                nresp++;
                checks++;
                if (resp_rdata !== 32'h12AB_8001) begin
                    errors++;
                    $display("FAIL b2b_rdata: got %h want 12ab8001", resp_rdata);
                end
            end
            @(negedge clk);
            if (acc == 3) req_valid = 1'b0;
        end
        checks++;
        if (acc !== 3 || acc_k[0] !== 0 || acc_k[1] !== 3 || acc_k[2] !== 6) begin
            errors++;
            $display("FAIL b2b_accepts: got n=%0d at %0d,%0d,%0d want 3 at 0,3,6", acc, acc_k[0], acc_k[1], acc_k[2]);
        end
        checks++;
        if (nresp !== 3 || busy_bad !== 0) begin
            errors++;
            $display("FAIL b2b_resp: got pulses=%0d ready_bad=%0d want 3 0", nresp, busy_bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
